// File: rtl/bitcnt_unit.sv
// Two-stage Zbb count unit (CPOP/CLZ/CTZ): S1 builds a count mask, S2 popcounts it.
// Latency: op accepted at edge N is on out_* after edge N+1 when S2 is free.
// Backpressure: holds up to 2 ops; in_ready drops once S1 is full and S2 is stalled.
module bitcnt_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_x,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [TAGW-1:0] out_tag
);

  localparam logic [1:0] OP_CPOP = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CTZ  = 2'b10;

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_mask_q, s1_mask_d;
  logic [TAGW-1:0] s1_tag_q;
  logic            out_valid_q, out_valid_d;
  logic [5:0]      res_q;
  logic [TAGW-1:0] out_tag_q;

  logic s2_free, in_fire, s1_adv;
  logic [31:0] lz_mask, tz_mask;
  logic [2:0]  nib [8];
  logic [3:0]  sum4 [4];
  logic [4:0]  sum5 [2];
  logic [5:0]  cnt;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && s2_free;

  // Leading/trailing zero-run masks: bit i set when every bit above (CLZ) or below (CTZ), inclusive, is zero.
  always_comb begin
    lz_mask = '0;
    tz_mask = '0;
    for (int i = 0; i < 32; i++) begin
      lz_mask[i] = ((in_x >> i) == '0);
      tz_mask[i] = ((in_x << (31 - i)) == '0);
    end
  end

  // Select the S1 mask by opcode; reserved opcode yields an empty mask (result 0).
  always_comb begin
    s1_mask_d = '0;
    case (in_op)
      OP_CPOP: s1_mask_d = in_x;
      OP_CLZ:  s1_mask_d = lz_mask;
      OP_CTZ:  s1_mask_d = tz_mask;
      default: s1_mask_d = '0;
    endcase
  end

  // Balanced popcount tree: nibble counts, then 4-, 5- and 6-bit pair sums.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      nib[j] = 3'(s1_mask_q[4*j]) + 3'(s1_mask_q[4*j+1])
             + 3'(s1_mask_q[4*j+2]) + 3'(s1_mask_q[4*j+3]);
    end
    for (int j = 0; j < 4; j++) sum4[j] = {1'b0, nib[2*j]} + {1'b0, nib[2*j+1]};
    for (int j = 0; j < 2; j++) sum5[j] = {1'b0, sum4[2*j]} + {1'b0, sum4[2*j+1]};
    cnt = {1'b0, sum5[0]} + {1'b0, sum5[1]};
  end

  // Occupancy bits: flush wins, then load/advance for S1, advance/drain for S2.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (in_fire)     s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
    if (s1_adv)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; data only moves on a transfer so stalled outputs stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mask_q   <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (in_fire) begin
        s1_mask_q <= s1_mask_d;
        s1_tag_q  <= in_tag;
      end
      if (s1_adv) begin
        res_q     <= cnt;
        out_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = {{(XLEN-6){1'b0}}, res_q};
  assign out_tag   = out_tag_q;

endmodule

// File: doc/bitcnt_unit.md
# bitcnt_unit

Two-stage pipelined count unit for the Zbb count instructions (CPOP, CLZ, CTZ) in the execute path. Stage 1 turns the operand into a count mask: the operand itself for CPOP, or the leading/trailing all-zero run for CLZ/CTZ. Stage 2 reduces that mask to a 6-bit population count using the single-cycle adder tree. The zero-extended result goes to writeback. Valid/ready handshakes sit on both sides, and a flush input handles branch mispredicts.

## Interface
Parameters:
- XLEN, 32, operand width; only 32 is supported.
- TAGW, 5, width of the destination-register tag carried alongside the data.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  drops all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts this cycle.
- in_op  in  2  00 CPOP, 01 CLZ, 10 CTZ, 11 reserved.
- in_x  in  XLEN  operand rs1.
- in_tag  in  TAGW  rd index, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_res  out  XLEN  count, zero-extended from 6 bits.
- out_tag  out  TAGW  tag of out_res.

## Operation
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (S1) registers s1_valid, s1_mask[31:0] and s1_tag. The mask m depends on in_op:
  - CPOP: m = x.
  - CLZ: m[i] = 1 iff x[31:i] == 0.
  - CTZ: m[i] = 1 iff x[i:0] == 0.
  - reserved (11): m = 0, so the result is 0.
- Stage 2 (S2) is the output register (out_valid, out_res, out_tag):
  - out_res = {26'b0, popcount(s1_mask)}.
  - The popcount is a balanced adder tree: pairs of 4-bit nibbles, then 3→4→5→6-bit sums.
- Stall logic:
  - s2_free = !out_valid || out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational and does not depend on in_valid.
- Hold rules:
  - While out_valid && !out_ready, out_res and out_tag hold stable.
  - The S1 registers also hold if S1 is occupied.
- Flush:
  - On a flush edge, s1_valid and out_valid go to 0.
  - An input transfer coinciding with flush is discarded.
  - An output transfer in the flush cycle still completes; the consumer has already sampled it.
  - Data registers need not be cleared.
- Arithmetic:
  - x = 0 gives CLZ = CTZ = 32 and CPOP = 0.
  - x = 0xFFFFFFFF gives CPOP = 32 and CLZ = CTZ = 0.
  - The maximum count is 32, so the 6-bit sum never overflows.
- No state machine beyond the two valid bits: occupancy is 0, 1 or 2 operations.

## Timing
- Reset values: s1_valid = 0, out_valid = 0, out_res = 0, out_tag = 0. in_ready reads 1 during and after reset.
- Reset asserted mid-operation discards everything immediately (asynchronous).
- Latency: an operation accepted at edge N is visible on out_* after edge N+1, provided S2 is free.
- Throughput: 1 operation/cycle with out_ready held high.
- Backpressure:
  - With out_ready low, the unit absorbs at most 2 operations.
  - in_ready then falls in the cycle after S1 fills.
- Simultaneous input and output transfers with a full pipe are legal and keep the pipe full. Ordering is strictly FIFO.
- The critical path is the S2 adder tree. Mask prefix-OR logic stays in S1.

## Test plan
- Reset: assert rst asynchronously mid-stream, then release → out_valid = 0, out_res = 0, out_tag = 0, in_ready = 1; no stale result emerges afterward.
- Op coverage: CPOP 0xF0F0_0001 → 9; CLZ 0x0001_0000 → 15; CTZ 0x0001_0000 → 16; CLZ/CTZ of 0 → 32; CPOP 0xFFFFFFFF → 32; op 11 → 0. Each arrives 2 edges after acceptance with the correct tag.
- Streaming: 100 back-to-back random ops with out_ready = 1 → one result per cycle, in order, all matching a software model.
- Backpressure: hold out_ready = 0 and offer 3 ops → exactly 2 accepted, in_ready = 0 on the third, out_res stable. Release → results in order, then the third op is accepted.
- Flush: flush with 2 ops in flight plus an input offered the same cycle → next cycle out_valid = 0, s1 empty. The discarded op never appears, and a subsequent op completes normally.
- Random out_ready toggling (50%) over 1000 ops → no loss, duplication or reordering, and out_res/out_tag never change while stalled.
